// File: rtl/inst_mem_responder.sv
// Memory-side responder for instruction fetches: one outstanding request, fixed
// access latency, valid/ready on both sides, plus a side-band preload port.
module inst_mem_responder #(
    parameter int                    ADDR_WIDTH = 64,
    parameter int                    INST_WIDTH = 32,
    parameter int                    DEPTH      = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 'h8000_0000,
    parameter int                    LATENCY    = 2,
    localparam int                   IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [INST_WIDTH-1:0] resp_inst_o,
    output logic                  resp_err_o,
    input  logic                  ld_en_i,
    input  logic [IDX_W-1:0]      ld_idx_i,
    input  logic [INST_WIDTH-1:0] ld_data_i,
    output logic [31:0]           fetch_cnt_o
);

    localparam int                    CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0]      CNT_LOAD = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A  = ADDR_WIDTH'(DEPTH);
    localparam logic [31:0]           DEPTH_W  = 32'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   err_q, err_d;
    logic                   zero_q, zero_d;
    logic [31:0]            fetch_cnt_q, fetch_cnt_d;
    logic [INST_WIDTH-1:0]  rd_word_q;
    logic [INST_WIDTH-1:0]  mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0]  addr_off;
    logic [ADDR_WIDTH-1:0]  word_off;
    logic [IDX_W-1:0]       rd_idx;
    logic                   fetch_err;
    logic                   accept;

    assign addr_off  = req_addr_i - BASE_ADDR;
    assign word_off  = addr_off >> 2;
    assign rd_idx    = word_off[IDX_W-1:0];
    assign fetch_err = (req_addr_i[1:0] != 2'b00) || (req_addr_i < BASE_ADDR) ||
                       (word_off >= DEPTH_A);
    assign accept    = req_valid_i && (state_q == ST_IDLE);

    // Array has no reset; the read at acceptance sees the pre-load word (read-before-write).
    always_ff @(posedge clk_i) begin
        if (ld_en_i && (32'(ld_idx_i) < DEPTH_W)) begin
            mem_q[ld_idx_i] <= ld_data_i;
        end
        if (accept) begin
            rd_word_q <= mem_q[rd_idx];
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        zero_d      = zero_q;
        fetch_cnt_d = fetch_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    err_d  = fetch_err;
                    zero_d = fetch_err;
                    if (LATENCY == 0) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                if (resp_ready_i) begin
                    state_d     = ST_IDLE;
                    fetch_cnt_d = fetch_cnt_q + 32'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            zero_q      <= 1'b1;
            fetch_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            zero_q      <= zero_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    // zero_q masks the un-reset read register after reset and on error fetches.
    assign req_ready_o  = (state_q == ST_IDLE);
    assign resp_valid_o = (state_q == ST_RESP);
    assign resp_inst_o  = zero_q ? '0 : rd_word_q;
    assign resp_err_o   = err_q;
    assign fetch_cnt_o  = fetch_cnt_q;

    a_req_valid_known: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (state_q == ST_IDLE) |-> !$isunknown(req_valid_i))
        else $error("req_valid_i is unknown while idle");

endmodule

// File: tb/tb_inst_mem_responder.sv
// Bench for inst_mem_responder: a LATENCY=2 and a LATENCY=0 instance, directed
// scenarios then random fetches checked against an array-based reference model.
module tb_inst_mem_responder;

    localparam logic [63:0] BASE = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b1;
    logic [1:0]  req_valid, req_ready, resp_valid, resp_ready, resp_err;
    logic [63:0] req_addr [2];
    logic [31:0] resp_inst [2];
    logic [31:0] fetch_cnt [2];
    logic        ld_en;
    logic [9:0]  ld_idx;
    logic [31:0] ld_data;

    int          n_assert = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          exp_cnt [2];
    logic [31:0] model_mem [1024];

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        inst_mem_responder #(
            .LATENCY((gi == 0) ? 2 : 0)
        ) u_dut (
            .clk_i       (clk),
            .rst_ni      (rst_ni),
            .req_valid_i (req_valid[gi]),
            .req_ready_o (req_ready[gi]),
            .req_addr_i  (req_addr[gi]),
            .resp_valid_o(resp_valid[gi]),
            .resp_ready_i(resp_ready[gi]),
            .resp_inst_o (resp_inst[gi]),
            .resp_err_o  (resp_err[gi]),
            .ld_en_i     (ld_en),
            .ld_idx_i    (ld_idx),
            .ld_data_i   (ld_data),
            .fetch_cnt_o (fetch_cnt[gi])
        );
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: word-addressed array starting at BASE, errors return zero.
    task automatic model_fetch(input logic [63:0] a, output logic e, output logic [31:0] w);
        logic [63:0] off;
        off = a - BASE;
        e = (a[1:0] != 2'b00) || (a < BASE) || ((off >> 2) >= 64'd1024);
        w = e ? 32'h0 : model_mem[off[11:2]];
    endtask

    task automatic load(input logic [9:0] i, input logic [31:0] v);
        ld_en = 1'b1; ld_idx = i; ld_data = v;
        @(negedge clk);
        model_mem[i] = v;
        ld_en = 1'b0;
    endtask

    task automatic step(input bit rnd_ld);
        logic [9:0]  li;
        logic [31:0] lv;
        li = 10'($urandom);
        lv = $urandom;
        if (rnd_ld) begin
            ld_en = 1'b1; ld_idx = li; ld_data = lv;
        end
        @(negedge clk);
        if (rnd_ld) model_mem[li] = lv;
        ld_en = 1'b0;
    endtask

    task automatic fetch(input int d, input logic [63:0] addr, input int hold,
                         input bit same_ld, input logic [9:0] sl_idx, input logic [31:0] sl_data,
                         input bit rnd_ld, output int acc_cyc);
        int          lat;
        logic        e_err;
        logic [31:0] e_inst;
        lat = (d == 0) ? 2 : 0;
        chk($sformatf("d%0d idle_req_ready", d), 64'(req_ready[d]), 64'd1);
        model_fetch(addr, e_err, e_inst);
        req_valid[d] = 1'b1;
        req_addr[d]  = addr;
        acc_cyc      = cyc;
        if (same_ld) begin
            ld_en = 1'b1; ld_idx = sl_idx; ld_data = sl_data;
        end
        @(negedge clk);
        if (same_ld) model_mem[sl_idx] = sl_data;
        req_valid[d] = 1'b0;
        req_addr[d]  = {$urandom, $urandom};
        ld_en        = 1'b0;
        for (int c = 0; c < lat; c++) begin
            chk($sformatf("d%0d early_resp_valid c%0d", d, c), 64'(resp_valid[d]), 64'd0);
            chk($sformatf("d%0d wait_req_ready", d), 64'(req_ready[d]), 64'd0);
            step(rnd_ld);
        end
        chk($sformatf("d%0d resp_valid a=%0h", d, addr), 64'(resp_valid[d]), 64'd1);
        chk($sformatf("d%0d resp_inst a=%0h", d, addr), 64'(resp_inst[d]), 64'(e_inst));
        chk($sformatf("d%0d resp_err a=%0h", d, addr), 64'(resp_err[d]), 64'(e_err));
        chk($sformatf("d%0d resp_req_ready", d), 64'(req_ready[d]), 64'd0);
        for (int h = 0; h < hold; h++) begin
            resp_ready[d] = 1'b0;
            step(rnd_ld);
            chk($sformatf("d%0d hold_valid h%0d", d, h), 64'(resp_valid[d]), 64'd1);
            chk($sformatf("d%0d hold_inst h%0d", d, h), 64'(resp_inst[d]), 64'(e_inst));
            chk($sformatf("d%0d hold_err h%0d", d, h), 64'(resp_err[d]), 64'(e_err));
            chk($sformatf("d%0d hold_req_ready h%0d", d, h), 64'(req_ready[d]), 64'd0);
        end
        resp_ready[d] = 1'b1;
        @(negedge clk);
        resp_ready[d] = 1'b0;
        exp_cnt[d]++;
        chk($sformatf("d%0d done_valid", d), 64'(resp_valid[d]), 64'd0);
        chk($sformatf("d%0d done_req_ready", d), 64'(req_ready[d]), 64'd1);
        chk($sformatf("d%0d fetch_cnt", d), 64'(fetch_cnt[d]), 64'(32'(exp_cnt[d])));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int          acc, prev;
        int          d, idx, kind, hold;
        logic [63:0] a;
        bit          sl;
        req_valid = '0; resp_ready = '0; ld_en = 1'b0; ld_idx = '0; ld_data = '0;
        req_addr[0] = '0; req_addr[1] = '0;
        exp_cnt[0] = 0; exp_cnt[1] = 0;
        #1 rst_ni = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("d%0d rst_req_ready", i), 64'(req_ready[i]), 64'd1);
            chk($sformatf("d%0d rst_resp_valid", i), 64'(resp_valid[i]), 64'd0);
            chk($sformatf("d%0d rst_resp_inst", i), 64'(resp_inst[i]), 64'd0);
            chk($sformatf("d%0d rst_resp_err", i), 64'(resp_err[i]), 64'd0);
            chk($sformatf("d%0d rst_fetch_cnt", i), 64'(fetch_cnt[i]), 64'd0);
        end
        @(negedge clk);
        rst_ni = 1'b1;

        for (int i = 0; i < 1024; i++) load(10'(i), $urandom);
        load(10'd0, 32'h0000_0413);
        load(10'd1, 32'h0010_0073);
        load(10'd2, 32'h0000_1111);
        load(10'd3, 32'h0000_2222);
        load(10'd5, 32'hDEAD_BEEF);

        fetch(0, BASE, 0, 0, '0, '0, 0, acc);
        fetch(0, BASE + 64'd4, 5, 0, '0, '0, 0, acc);
        fetch(0, BASE + 64'd2, 0, 0, '0, '0, 0, acc);
        fetch(0, BASE + 64'h1000, 0, 0, '0, '0, 0, acc);
        fetch(0, 64'h7FFF_FFFC, 0, 0, '0, '0, 0, acc);

        prev = 0;
        for (int i = 0; i < 4; i++) begin
            fetch(1, BASE + 64'(4 * i), 0, 0, '0, '0, 0, acc);
            if (i > 0) chk($sformatf("d1 throughput i%0d", i), 64'(acc - prev), 64'd2);
            prev = acc;
        end

        fetch(0, BASE + 64'd20, 0, 1, 10'd5, 32'h1234_5678, 0, acc);
        fetch(0, BASE + 64'd20, 0, 0, '0, '0, 0, acc);

        for (int t = 0; t < 60; t++) begin
            d    = $urandom_range(0, 1);
            idx  = $urandom_range(0, 1023);
            kind = $urandom_range(0, 9);
            hold = $urandom_range(0, 3);
            case (kind)
                0: a = BASE + 64'(4 * idx) + 64'($urandom_range(1, 3));
                1: a = BASE - 64'(4 * $urandom_range(1, 100));
                2: a = BASE + 64'h1000 + 64'(4 * $urandom_range(0, 1000));
                3: a = {32'h1, 32'h0} + BASE + 64'(4 * idx);
                default: a = BASE + 64'(4 * idx);
            endcase
            sl = ($urandom_range(0, 3) == 0);
            fetch(d, a, hold, sl, sl ? 10'(idx) : 10'($urandom), $urandom,
                  $urandom_range(0, 1) == 1, acc);
        end

        req_valid[0] = 1'b1;
        req_addr[0]  = BASE + 64'd8;
        @(negedge clk);
        req_valid[0] = 1'b0;
        #2 rst_ni = 1'b0;
        #1;
        exp_cnt[0] = 0; exp_cnt[1] = 0;
        chk("async_rst resp_valid", 64'(resp_valid[0]), 64'd0);
        chk("async_rst req_ready", 64'(req_ready[0]), 64'd1);
        chk("async_rst resp_inst", 64'(resp_inst[0]), 64'd0);
        chk("async_rst resp_err", 64'(resp_err[0]), 64'd0);
        chk("async_rst fetch_cnt", 64'(fetch_cnt[0]), 64'd0);
        chk("async_rst fetch_cnt d1", 64'(fetch_cnt[1]), 64'd0);
        @(negedge clk);
        rst_ni = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk($sformatf("post_rst resp_valid c%0d", c), 64'(resp_valid[0]), 64'd0);
            chk($sformatf("post_rst req_ready c%0d", c), 64'(req_ready[0]), 64'd1);
        end
        chk("post_rst fetch_cnt", 64'(fetch_cnt[0]), 64'(32'(exp_cnt[0])));
        fetch(0, BASE + 64'd4, 1, 0, '0, '0, 0, acc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_mem_responder.md
Name: inst_mem_responder

Overview:
- Memory-side end of the CPU instruction-fetch interface: accepts a fetch address from the IFU and returns one 32-bit instruction word.
- Word-addressed instruction array; fixed, parameterised access latency; valid/ready handshakes on both request and response.
- Side-band load port for preloading programs from the testbench.
- Completed-fetch counter for the simulation harness.

Parameters:
- ADDR_WIDTH, 64, fetch address width (matches PC width)
- INST_WIDTH, 32, instruction word width
- DEPTH, 1024, number of instruction words in the array
- BASE_ADDR, 64'h8000_0000, byte address of word 0
- LATENCY, 2, wait cycles between request acceptance and response (0 allowed)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  IFU presents a fetch address
- req_ready  out  1  responder can accept a request
- req_addr  in  ADDR_WIDTH  byte address of the fetch
- resp_valid  out  1  response word valid
- resp_ready  in  1  IFU accepts the response
- resp_inst  out  INST_WIDTH  fetched instruction
- resp_err  out  1  fetch was misaligned or out of range
- ld_en  in  1  write enable for the load port
- ld_idx  in  clog2(DEPTH)  word index to write
- ld_data  in  INST_WIDTH  word to write
- fetch_cnt  out  32  number of completed response handshakes

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, req_ready=1, resp_valid=0, resp_inst=0, resp_err=0, fetch_cnt=0.
  - Latency counter cleared.
  - Array contents are not reset.
- Reset mid-transaction drops the pending fetch; no response is issued for it.
- States: IDLE, WAIT, RESP.
  - req_ready = (state==IDLE); it is a decode of registered state only.
- Acceptance happens on a rising edge with req_valid && req_ready.
  - Compute off = req_addr - BASE_ADDR (ADDR_WIDTH-bit unsigned).
  - err = (req_addr[1:0]!=0) || (req_addr < BASE_ADDR) || (off>>2 >= DEPTH).
  - The word at index off>>2 is snapshotted into a holding register at the acceptance edge. Forced to 0 when err.
  - Next state: WAIT if LATENCY>0 (counter loaded with LATENCY-1); RESP if LATENCY==0.
- WAIT: counter decrements each cycle. When the counter reaches 0, the next state is RESP.
- RESP:
  - resp_valid=1; resp_inst and resp_err come from the holding register.
  - Outputs stay stable until resp_valid && resp_ready.
  - On that edge: go to IDLE, fetch_cnt increments (wraps at 2^32), resp_valid drops next cycle.
- Timing: a request accepted at edge T gives resp_valid high from the cycle after edge T+LATENCY.
  - Best case: one fetch per LATENCY+2 cycles.
  - No request pipelining; only one outstanding request.
- Load port:
  - On every edge with ld_en=1, array[ld_idx] <= ld_data, in any state.
  - ld_idx >= DEPTH is ignored.
  - A load on the same edge as acceptance at the same index: the old word is returned (read-before-write).
  - Loads after acceptance never alter a pending response.
- Error responses still complete the handshake normally and increment fetch_cnt.
- req_addr and req_valid are ignored outside IDLE.
- X on req_valid while in IDLE is a verification error and is flagged by assertion.

Test Plan:
- Preload idx0=32'h0000_0413, idx1=32'h0010_0073; fetch 0x8000_0000 with resp_ready=1.
  - Required: resp_valid high 3 cycles after acceptance, resp_inst=32'h0000_0413, resp_err=0, fetch_cnt=1.
- Fetch 0x8000_0004 with resp_ready held 0 for 5 cycles.
  - Required: resp_valid stays 1 and resp_inst stays 32'h0010_0073 throughout, req_ready=0.
  - Required after resp_ready=1: IDLE next cycle, fetch_cnt=2.
- Fetch 0x8000_0002, then 0x8000_1000, then 0x7FFF_FFFC.
  - Required for each: resp_err=1, resp_inst=0, handshake completes, fetch_cnt increments.
- LATENCY=0 build, back-to-back fetches of idx0..idx3 with resp_ready=1.
  - Required: each resp_valid one cycle after acceptance, one fetch per 2 cycles, words returned in order.
- Accept fetch of idx5 (preloaded 32'hDEAD_BEEF) with ld_en=1, ld_idx=5, ld_data=32'h1234_5678 on the same edge.
  - Required: response 32'hDEAD_BEEF; a subsequent fetch of idx5 returns 32'h1234_5678.
- Assert rst=0 asynchronously while in WAIT.
  - Required: outputs go to reset values immediately, no resp_valid after release, req_ready=1, fetch_cnt=0.
